// File: rtl/demorgan_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demorgan_sweep_ctrl_pkg
//  Description : Shared types and constants for the De Morgan sweep sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package demorgan_sweep_ctrl_pkg;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Truth-table combination indices, {A,B}
    localparam logic [1:0] C00 = 2'b00;
    localparam logic [1:0] C01 = 2'b01;
    localparam logic [1:0] C10 = 2'b10;
    localparam logic [1:0] C11 = 2'b11;

endpackage : demorgan_sweep_ctrl_pkg
`default_nettype wire

// File: rtl/demorgan_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : demorgan_sweep_ctrl_if
//  Description : Control/status bus between the self-check master and the
//                De Morgan sweep sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demorgan_sweep_ctrl_if;

    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_vec;
    logic [2:0] err_count;
    logic [1:0] combo;

    // Test/self-check master side
    modport master (
        output start, abort,
        input  busy, done, pass, err_vec, err_count, combo
    );

    // Sequencer side
    modport slave (
        input  start, abort,
        output busy, done, pass, err_vec, err_count, combo
    );

endinterface : demorgan_sweep_ctrl_if
`default_nettype wire

// File: rtl/demorgan_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : demorgan_sweep_ctrl
//  Description : BIST-style sequencer that sweeps A/B through 00,01,10,11,
//                waits a settle window on each, checks both De Morgan
//                identities and reports per-combination errors and pass/fail.
//  Revision    : 1.0 - initial release
// ============================================================================
module demorgan_sweep_ctrl
    import demorgan_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    demorgan_sweep_ctrl_if.slave    ctl,
    output logic                    dut_a,
    output logic                    dut_b,
    input  wire logic               nandn_i,
    input  wire logic               nor_i,
    input  wire logic               norn_i,
    input  wire logic               nand_i
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [1:0]      combo;
    logic [3:0]      err_vec;
    logic [2:0]      err_count;
    logic            pass;
    logic            mismatch;
    logic            abort_hit;

    // Either identity failing for the combination currently applied
    assign mismatch  = (nandn_i != nor_i) | (norn_i != nand_i);
    // Abort only acts outside IDLE; in IDLE it merely blocks start
    assign abort_hit = ctl.abort && (state != ST_IDLE);

    assign ctl.busy      = (state != ST_IDLE);
    assign ctl.done      = (state == ST_DONE);
    assign ctl.pass      = pass;
    assign ctl.err_vec   = err_vec;
    assign ctl.err_count = err_count;
    assign ctl.combo     = combo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ctl.start && !ctl.abort) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SW'(1)) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = (combo == C11) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    // Sweep datapath: drive A/B, settle counter, error accumulation, verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            settle_cnt <= '0;
            combo      <= C00;
            err_vec    <= 4'b0000;
            err_count  <= 3'd0;
            pass       <= 1'b0;
        end else if (abort_hit) begin
            // Partial error results stay visible; the verdict is withdrawn
            dut_a <= 1'b0;
            dut_b <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl.start && !ctl.abort) begin
                        combo     <= C00;
                        err_vec   <= 4'b0000;
                        err_count <= 3'd0;
                        pass      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    {dut_a, dut_b} <= combo;
                    settle_cnt     <= SW'(SETTLE_CYCLES);
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - SW'(1);
                end
                ST_CHECK: begin
                    err_vec[combo] <= mismatch;
                    err_count      <= err_count + {2'b00, mismatch};
                    if (combo == C11) begin
                        // Verdict computed from the final error vector here so
                        // that it is already valid in the DONE cycle
                        pass <= ({mismatch, err_vec[2:0]} == 4'b0000);
                    end else begin
                        combo <= combo + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : demorgan_sweep_ctrl
`default_nettype wire

// File: tb/tb_demorgan_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demorgan_sweep_ctrl
//  Description : Self-checking bench for demorgan_sweep_ctrl with a fault-
//                injectable De Morgan gate model, SETTLE_CYCLES of 1 and 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demorgan_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    int         sel = 1;
    logic       start_v = 1'b0;
    logic       abort_v = 1'b0;
    logic [3:0] fmask = 4'b0000;
    logic [3:0] fsel  = 4'b0000;

    always #5 clk = ~clk;

    demorgan_sweep_ctrl_if bus1();
    demorgan_sweep_ctrl_if bus3();

    assign bus1.start = (sel == 1) && start_v;
    assign bus1.abort = (sel == 1) && abort_v;
    assign bus3.start = (sel == 3) && start_v;
    assign bus3.abort = (sel == 3) && abort_v;

    // Gate models: fmask[k] corrupts combo k, fsel[k] picks nand (1) or nor (0)
    logic       a1, b1, a3, b3;
    logic [1:0] i1, i3;
    logic       nandn1, nor1, norn1, nand1;
    logic       nandn3, nor3, norn3, nand3;
    assign i1     = {a1, b1};
    assign i3     = {a3, b3};
    assign nandn1 = ~a1 & ~b1;
    assign norn1  = ~a1 | ~b1;
    assign nor1   = ~(a1 | b1) ^ (fmask[i1] & ~fsel[i1]);
    assign nand1  = ~(a1 & b1) ^ (fmask[i1] &  fsel[i1]);
    assign nandn3 = ~a3 & ~b3;
    assign norn3  = ~a3 | ~b3;
    assign nor3   = ~(a3 | b3) ^ (fmask[i3] & ~fsel[i3]);
    assign nand3  = ~(a3 & b3) ^ (fmask[i3] &  fsel[i3]);

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ctl(bus1.slave),
        .dut_a(a1), .dut_b(b1),
        .nandn_i(nandn1), .nor_i(nor1), .norn_i(norn1), .nand_i(nand1)
    );

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .ctl(bus3.slave),
        .dut_a(a3), .dut_b(b3),
        .nandn_i(nandn3), .nor_i(nor3), .norn_i(norn3), .nand_i(nand3)
    );

    // View of whichever instance is currently selected
    logic       v_busy, v_done, v_pass, v_a, v_b;
    logic [3:0] v_ev;
    logic [2:0] v_ec;
    logic [1:0] v_combo;
    assign v_busy  = (sel == 3) ? bus3.busy      : bus1.busy;
    assign v_done  = (sel == 3) ? bus3.done      : bus1.done;
    assign v_pass  = (sel == 3) ? bus3.pass      : bus1.pass;
    assign v_ev    = (sel == 3) ? bus3.err_vec   : bus1.err_vec;
    assign v_ec    = (sel == 3) ? bus3.err_count : bus1.err_count;
    assign v_combo = (sel == 3) ? bus3.combo     : bus1.combo;
    assign v_a     = (sel == 3) ? a3 : a1;
    assign v_b     = (sel == 3) ? b3 : b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep from the IDLE state; called at a negedge.
    // Edge 0 samples start; after edge n the sweep is in combo n/per, phase
    // n%per (0 drive, 1..S settle, S+1 check); DONE follows edge 4*per.
    task automatic sweep(input logic [3:0] mask, input logic [3:0] fs, input bit poke);
        int per;
        int c;
        int p;
        logic [31:0] ab;
        per   = ((sel == 3) ? 3 : 1) + 2;
        fmask = mask;
        fsel  = fs;
        start_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v = 1'b0;
        for (int n = 1; n <= 4 * per; n++) begin
            @(posedge clk);
            @(negedge clk);
            c  = n / per;
            p  = n % per;
            ab = {30'd0, v_a, v_b};
            if (n == 1) begin
                chk("cleared_err_vec", v_ev, 0);
                chk("cleared_err_count", v_ec, 0);
                chk("cleared_pass", v_pass, 0);
            end
            if (n < 4 * per) begin
                chk("busy_in_sweep", v_busy, 1);
                chk("no_early_done", v_done, 0);
                if (p >= 1) begin
                    chk("ab_value", ab, c);
                    chk("combo_value", v_combo, c);
                end
                start_v = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                start_v = 1'b0;
                chk("done_pulse", v_done, 1);
                chk("done_busy", v_busy, 1);
                chk("pass_at_done", v_pass, (mask == 4'b0000));
                chk("err_vec_at_done", v_ev, mask);
                chk("err_count_at_done", v_ec, $countones(mask));
            end
        end
        @(posedge clk);
        @(negedge clk);
        ab = {30'd0, v_a, v_b};
        chk("done_one_cycle", v_done, 0);
        chk("idle_after_done", v_busy, 0);
        chk("ab_held_11", ab, 3);
        chk("pass_held", v_pass, (mask == 4'b0000));
        chk("err_vec_held", v_ev, mask);
        // A start seen while busy must not have been queued
        @(posedge clk);
        @(negedge clk);
        chk("no_queued_start", v_busy, 0);
    endtask

    initial begin
        int seen;
        logic [31:0] ab;
        // Reset with start asserted: everything at zero
        rst_n   = 1'b0;
        sel     = 1;
        start_v = 1'b1;
        @(negedge clk);
        chk("rst_busy", v_busy, 0);
        chk("rst_done", v_done, 0);
        chk("rst_pass", v_pass, 0);
        chk("rst_err_vec", v_ev, 0);
        chk("rst_err_count", v_ec, 0);
        chk("rst_combo", v_combo, 0);
        chk("rst_ab", {v_a, v_b}, 0);
        chk("rst_busy_s3", bus3.busy, 0);
        start_v = 1'b0;
        rst_n   = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_release", v_busy, 0);
        chk("idle_no_done", v_done, 0);

        // SETTLE_CYCLES=1: good gate, single fault on combo 2, random faults
        sweep(4'b0000, 4'b0000, 1'b0);
        sweep(4'b0100, 4'b0000, 1'b0);
        repeat (4) sweep(4'($urandom_range(0, 15)), 4'($urandom), 1'b0);
        sweep(4'($urandom_range(0, 15)), 4'($urandom), 1'b1);

        // SETTLE_CYCLES=3
        sel = 3;
        sweep(4'b0000, 4'b0000, 1'b0);
        sweep(4'b0100, 4'b1011, 1'b1);
        repeat (2) sweep(4'($urandom_range(0, 15)), 4'($urandom), 1'b0);

        // Abort during combo 2 SETTLE (after edge 2*per+1, per=5)
        fmask   = 4'b1111;
        fsel    = 4'($urandom);
        start_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v = 1'b0;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_abort_combo", v_combo, 2);
        abort_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_v = 1'b0;
        ab = {30'd0, v_a, v_b};
        chk("abort_idle", v_busy, 0);
        chk("abort_no_done", v_done, 0);
        chk("abort_ab_zero", ab, 0);
        chk("abort_partial_err_vec", v_ev, 4'b0011);
        chk("abort_partial_count", v_ec, 2);
        chk("abort_pass", v_pass, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (v_done) seen++;
        end
        chk("abort_done_never", seen, 0);
        sweep(4'b0000, 4'b0000, 1'b0);

        // start and abort together in IDLE: stays IDLE
        start_v = 1'b1;
        abort_v = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("start_abort_busy", v_busy, 0);
            chk("start_abort_done", v_done, 0);
        end
        start_v = 1'b0;
        abort_v = 1'b0;
        sel = 1;
        @(negedge clk);
        chk("start_abort_s1_pass_held", v_pass, bus1.err_vec == 4'b0000 ? 1'b1 : 1'b0);
        sweep(4'($urandom_range(0, 15)), 4'($urandom), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demorgan_sweep_ctrl
`default_nettype wire
